// File: rtl/riscv_pkg.sv
// Shared constants and the fetch FSM encoding used by the instruction fetch stage.
package riscv_pkg;

  localparam int          BUS_WIDTH        = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Shift-register FIFO of {pc, instr} entries; entry 0 is the registered head word.
module riscv_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] entries [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    // A simultaneous pop shifts everything down, so the write lands one slot lower.
    wr_idx  = AW'(do_pop ? count - CW'(1) : count);
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    dout    = entries[0];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        entries[i] <= entries[i+1];
      end
    end
    if (do_push) begin
      entries[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, response buffer, redirect flush.
// Optional macro RISCV_FETCH_ALIGN_CHECK_EN adds o_MISALIGN, a one-cycle pulse after a misaligned redirect.
module riscv_fetch_unit #(
  parameter int                   BUS_WIDTH  = riscv_pkg::BUS_WIDTH,
  parameter logic [BUS_WIDTH-1:0] RESET_PC   = BUS_WIDTH'(riscv_pkg::RESET_PC_DEFAULT),
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  output logic                 o_MISALIGN,
`endif
  output logic [BUS_WIDTH-1:0] o_ADDR,
  output logic                 o_REQ,
  input  logic                 i_GNT,
  input  logic [BUS_WIDTH-1:0] i_DATA,
  input  logic                 i_DATA_VALID,
  input  logic                 i_REDIRECT,
  input  logic [BUS_WIDTH-1:0] i_REDIRECT_PC,
  output logic [BUS_WIDTH-1:0] o_INSTR,
  output logic [BUS_WIDTH-1:0] o_PC,
  output logic                 o_VALID,
  input  logic                 i_READY
);

  import riscv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 2 * BUS_WIDTH;

  fetch_state_e         state;
  fetch_state_e         state_next;
  logic [BUS_WIDTH-1:0] addr;
  logic [BUS_WIDTH-1:0] resp_pc;
  logic [BUS_WIDTH-1:0] redirect_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        drop_redir;
  logic [CW-1:0]        drop_dec;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          credit;
  logic                 req;
  logic                 grant;
  logic                 resp_take;
  logic                 dv_counted;
  logic                 flush_dec;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [EW-1:0]        head;

  always_comb begin
    redirect_pc = {i_REDIRECT_PC[BUS_WIDTH-1:2], 2'b00};
    credit      = {1'b0, outstanding} + {1'b0, fifo_count};
    req         = (state == ST_RUN) && (credit < (CW+1)'(FIFO_DEPTH)) && !i_REDIRECT;
    grant       = req && i_GNT;
    resp_take   = (state == ST_RUN) && i_DATA_VALID && (outstanding != '0) && !i_REDIRECT;
    // A response only counts against the drop tally if something was actually expected.
    dv_counted  = i_DATA_VALID && ((drop_cnt != '0) || (outstanding != '0));
    drop_redir  = drop_cnt + outstanding - CW'(dv_counted);
    flush_dec   = (state == ST_FLUSH) && i_DATA_VALID && (drop_cnt != '0);
    drop_dec    = drop_cnt - CW'(flush_dec);
    pop         = !fifo_empty && i_READY && !i_REDIRECT;
    push        = resp_take && (!fifo_full || pop);
  end

  always_comb begin
    state_next = state;
    if (i_REDIRECT) begin
      state_next = (drop_redir != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state)
        ST_BOOT:  state_next = ST_RUN;
        ST_RUN:   state_next = ST_RUN;
        ST_FLUSH: state_next = (drop_dec == '0) ? ST_RUN : ST_FLUSH;
        default:  state_next = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state       <= ST_BOOT;
      addr        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state <= state_next;
      if (i_REDIRECT) begin
        addr        <= redirect_pc;
        resp_pc     <= redirect_pc;
        outstanding <= '0;
        drop_cnt    <= drop_redir;
      end else begin
        if (grant) begin
          addr <= addr + BUS_WIDTH'(PC_INC);
        end
        if (resp_take) begin
          resp_pc <= resp_pc + BUS_WIDTH'(PC_INC);
        end
        outstanding <= outstanding + CW'(grant) - CW'(resp_take);
        drop_cnt    <= drop_dec;
      end
    end
  end

`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_MISALIGN <= 1'b0;
    end else begin
      o_MISALIGN <= i_REDIRECT && (i_REDIRECT_PC[1:0] != 2'b00);
    end
  end
`endif

  riscv_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_CLK),
    .rst   (i_RST),
    .flush (i_REDIRECT),
    .push  (push),
    .din   ({resp_pc, i_DATA}),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs read as zero whenever the buffer is empty.
  always_comb begin
    o_ADDR  = addr;
    o_REQ   = req;
    o_VALID = !fifo_empty;
    o_PC    = fifo_empty ? '0 : head[EW-1:BUS_WIDTH];
    o_INSTR = fifo_empty ? '0 : head[BUS_WIDTH-1:0];
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: two instances (RESET_PC 0x100 and 0xFFFFFFFC) with 1-cycle memory models.
module tb_riscv_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr [2];
  logic [31:0] data [2];
  logic [31:0] rpc  [2];
  logic [31:0] instr[2];
  logic [31:0] pc   [2];
  logic        req  [2];
  logic        gnt  [2];
  logic        dv   [2];
  logic        redir[2];
  logic        valid[2];
  logic        ready[2];
  logic        mem_en[2];
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  logic        mis  [2];
`endif

  int tests = 0;
  int fails = 0;
  int ngrant0 = 0;
  logic [31:0] pend0[$];
  logic [31:0] pend1[$];
  logic [31:0] gaddr0[$];
  logic [31:0] obs_pc0[$];
  logic [31:0] obs_in0[$];

  riscv_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut0 (
    .i_CLK(clk), .i_RST(rst),
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    .o_MISALIGN(mis[0]),
`endif
    .o_ADDR(addr[0]), .o_REQ(req[0]), .i_GNT(gnt[0]), .i_DATA(data[0]),
    .i_DATA_VALID(dv[0]), .i_REDIRECT(redir[0]), .i_REDIRECT_PC(rpc[0]),
    .o_INSTR(instr[0]), .o_PC(pc[0]), .o_VALID(valid[0]), .i_READY(ready[0])
  );

  riscv_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .i_CLK(clk), .i_RST(rst),
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    .o_MISALIGN(mis[1]),
`endif
    .o_ADDR(addr[1]), .o_REQ(req[1]), .i_GNT(gnt[1]), .i_DATA(data[1]),
    .i_DATA_VALID(dv[1]), .i_REDIRECT(redir[1]), .i_REDIRECT_PC(rpc[1]),
    .o_INSTR(instr[1]), .o_PC(pc[1]), .o_VALID(valid[1]), .i_READY(ready[1])
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // One clock: record handshakes seen before the edge, then update the memory models.
  task automatic tick();
    logic        r, g0, g1, t0;
    logic [31:0] a0, a1, p0, i0;
    r  = rst;
    g0 = !r && req[0] && gnt[0];  a0 = addr[0];
    g1 = !r && req[1] && gnt[1];  a1 = addr[1];
    t0 = !r && valid[0] && ready[0] && !redir[0];
    p0 = pc[0];  i0 = instr[0];
    @(posedge clk);
    #1;
    if (r) begin
      pend0.delete();
      pend1.delete();
    end
    if (g0) begin pend0.push_back(a0); gaddr0.push_back(a0); ngrant0++; end
    if (g1) pend1.push_back(a1);
    if (t0) begin obs_pc0.push_back(p0); obs_in0.push_back(i0); end
    if (!rst && mem_en[0] && pend0.size() > 0) begin dv[0] = 1'b1; data[0] = mem_word(pend0.pop_front()); end
    else begin dv[0] = 1'b0; data[0] = 32'h0; end
    if (!rst && mem_en[1] && pend1.size() > 0) begin dv[1] = 1'b1; data[1] = mem_word(pend1.pop_front()); end
    else begin dv[1] = 1'b0; data[1] = 32'h0; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    gaddr0.delete(); obs_pc0.delete(); obs_in0.delete(); ngrant0 = 0;
  endtask

  task automatic test_reset();
    logic [31:0] rpc_exp;
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      rpc_exp = (k == 0) ? 32'h0000_0100 : 32'hFFFF_FFFC;
      tests++; if (addr[k] !== rpc_exp) begin fails++; $display("FAIL reset_addr[%0d]: got %h expected %h", k, addr[k], rpc_exp); end
      tests++; if (req[k] !== 1'b0) begin fails++; $display("FAIL reset_req[%0d]: got %b expected 0", k, req[k]); end
      tests++; if (valid[k] !== 1'b0) begin fails++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, valid[k]); end
      tests++; if (instr[k] !== 32'h0) begin fails++; $display("FAIL reset_instr[%0d]: got %h expected 0", k, instr[k]); end
      tests++; if (pc[k] !== 32'h0) begin fails++; $display("FAIL reset_pc[%0d]: got %h expected 0", k, pc[k]); end
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
      tests++; if (mis[k] !== 1'b0) begin fails++; $display("FAIL reset_misalign[%0d]: got %b expected 0", k, mis[k]); end
`endif
    end
    rst = 1'b0;
    tick();
    tests++; if (req[0] !== 1'b1) begin fails++; $display("FAIL boot_to_run_req: got %b expected 1", req[0]); end
  endtask

  task automatic test_stream();
    gnt[0] = 1'b1; ready[0] = 1'b1; mem_en[0] = 1'b1;
    do_reset();
    tests++; if (req[0] !== 1'b1 || addr[0] !== 32'h100) begin fails++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00000100", req[0], addr[0]); end
    tick();
    tests++; if (valid[0] !== 1'b0) begin fails++; $display("FAIL stream_no_bypass: got valid=%b expected 0", valid[0]); end
    tick();
    tests++; if (valid[0] !== 1'b1 || pc[0] !== 32'h100 || instr[0] !== mem_word(32'h100)) begin
      fails++; $display("FAIL stream_latency: got valid=%b pc=%h instr=%h expected 1 00000100 %h", valid[0], pc[0], instr[0], mem_word(32'h100));
    end
    for (int c = 0; c < 27; c++) tick();
    tests++; if (obs_pc0.size() < 15) begin fails++; $display("FAIL stream_rate: got %0d instructions expected at least 15", obs_pc0.size()); end
    for (int i = 0; i < 8 && i < gaddr0.size(); i++) begin
      tests++; if (gaddr0[i] !== 32'h100 + 32'(4*i)) begin fails++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, gaddr0[i], 32'h100 + 32'(4*i)); end
    end
    for (int i = 0; i < 8 && i < obs_pc0.size(); i++) begin
      tests++; if (obs_pc0[i] !== 32'h100 + 32'(4*i) || obs_in0[i] !== mem_word(32'h100 + 32'(4*i))) begin
        fails++; $display("FAIL stream_out[%0d]: got pc=%h instr=%h expected pc=%h", i, obs_pc0[i], obs_in0[i], 32'h100 + 32'(4*i));
      end
    end
  endtask

  task automatic test_backpressure();
    int hold_bad;
    gnt[0] = 1'b1; ready[0] = 1'b0; mem_en[0] = 1'b1;
    do_reset();
    hold_bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid[0] && pc[0] !== 32'h100) hold_bad++;
    end
    tests++; if (ngrant0 !== 2) begin fails++; $display("FAIL bp_grants: got %0d expected 2", ngrant0); end
    tests++; if (valid[0] !== 1'b1 || pc[0] !== 32'h100) begin fails++; $display("FAIL bp_head: got valid=%b pc=%h expected 1 00000100", valid[0], pc[0]); end
    tests++; if (hold_bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad); end
    ready[0] = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    tests++; if (obs_pc0.size() < 3) begin fails++; $display("FAIL bp_release_count: got %0d expected at least 3", obs_pc0.size()); end
    for (int i = 0; i < obs_pc0.size() && i < 10; i++) begin
      tests++; if (obs_pc0[i] !== 32'h100 + 32'(4*i)) begin fails++; $display("FAIL bp_order[%0d]: got %h expected %h", i, obs_pc0[i], 32'h100 + 32'(4*i)); end
    end
  endtask

  task automatic test_no_grant();
    gnt[0] = 1'b0; ready[0] = 1'b1; mem_en[0] = 1'b1;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if (req[0] !== 1'b1 || addr[0] !== 32'h100 || valid[0] !== 1'b0) begin
        fails++; $display("FAIL nogrant[%0d]: got req=%b addr=%h valid=%b expected 1 00000100 0", c, req[0], addr[0], valid[0]);
      end
    end
  endtask

  task automatic test_redirect_flush();
    bit seen;
    gnt[0] = 1'b1; ready[0] = 1'b1; mem_en[0] = 1'b0;
    do_reset();
    tick();
    tick();
    tests++; if (ngrant0 !== 2 || req[0] !== 1'b0) begin fails++; $display("FAIL flush_inflight: got grants=%0d req=%b expected 2 0", ngrant0, req[0]); end
    redir[0] = 1'b1; rpc[0] = 32'h0000_2000;
    tick();
    redir[0] = 1'b0; mem_en[0] = 1'b1;
    tests++; if (addr[0] !== 32'h2000 || req[0] !== 1'b0 || valid[0] !== 1'b0) begin
      fails++; $display("FAIL flush_enter: got addr=%h req=%b valid=%b expected 00002000 0 0", addr[0], req[0], valid[0]);
    end
    tick();
    tests++; if (req[0] !== 1'b0) begin fails++; $display("FAIL flush_hold_req: got %b expected 0", req[0]); end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (valid[0]) begin
        seen = 1'b1;
        tests++; if (pc[0] !== 32'h2000 || instr[0] !== mem_word(32'h2000)) begin
          fails++; $display("FAIL flush_first_pc: got pc=%h instr=%h expected 00002000 %h", pc[0], instr[0], mem_word(32'h2000));
        end
      end
    end
    if (!seen) begin tests++; fails++; $display("FAIL flush_timeout: got no o_VALID expected pc 00002000"); end
  endtask

  task automatic test_redirect_align();
    bit seen;
    gnt[0] = 1'b1; ready[0] = 1'b1; mem_en[0] = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) tick();
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    tests++; if (mis[0] !== 1'b0) begin fails++; $display("FAIL misalign_idle: got %b expected 0", mis[0]); end
`endif
    redir[0] = 1'b1; rpc[0] = 32'h0000_2003;
    tick();
    redir[0] = 1'b0;
    tests++; if (addr[0] !== 32'h2000 || valid[0] !== 1'b0) begin fails++; $display("FAIL align_addr: got addr=%h valid=%b expected 00002000 0", addr[0], valid[0]); end
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    tests++; if (mis[0] !== 1'b1) begin fails++; $display("FAIL misalign_pulse: got %b expected 1", mis[0]); end
`endif
    tick();
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    tests++; if (mis[0] !== 1'b0) begin fails++; $display("FAIL misalign_clear: got %b expected 0", mis[0]); end
`endif
    seen = valid[0];
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = valid[0];
    end
    tests++; if (!seen || pc[0] !== 32'h2000) begin fails++; $display("FAIL align_first_pc: got valid=%b pc=%h expected 1 00002000", seen, pc[0]); end
  endtask

  task automatic test_wrap_and_reset_full();
    logic [31:0] got[2];
    int n;
    gnt[1] = 1'b1; ready[1] = 1'b1; mem_en[1] = 1'b1;
    do_reset();
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      tick();
      if (valid[1]) begin
        got[n] = pc[n == 0 ? 1 : 1];
        n++;
      end
    end
    tests++; if (n !== 2) begin fails++; $display("FAIL wrap_count: got %0d expected 2", n); end
    else begin
      tests++; if (got[0] !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc0: got %h expected fffffffc", got[0]); end
      tests++; if (got[1] !== 32'h0000_0000) begin fails++; $display("FAIL wrap_pc1: got %h expected 00000000", got[1]); end
    end
    ready[1] = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    tests++; if (valid[1] !== 1'b1) begin fails++; $display("FAIL full_before_reset: got valid=%b expected 1", valid[1]); end
    rst = 1'b1;
    tick();
    tests++; if (valid[1] !== 1'b0 || addr[1] !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL reset_when_full: got valid=%b addr=%h expected 0 fffffffc", valid[1], addr[1]);
    end
    rst = 1'b0;
    gnt[1] = 1'b0; ready[1] = 1'b0; mem_en[1] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      gnt[k] = 1'b0; dv[k] = 1'b0; data[k] = 32'h0; redir[k] = 1'b0;
      rpc[k] = 32'h0; ready[k] = 1'b0; mem_en[k] = 1'b0;
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_no_grant();
    test_redirect_flush();
    test_redirect_align();
    test_wrap_and_reset_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
